// File: rtl/regread_issue_if.sv
// Bundle of the decode/issue stage's upstream, regfile, writeback and execute signals.
// master = surrounding pipeline/regfile side, slave = the issue stage itself.
interface regread_issue_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_instr;
  logic [DW-1:0] in_pc;
  logic [AW-1:0] ReadA;
  logic [AW-1:0] ReadB;
  logic [DW-1:0] OutA;
  logic [DW-1:0] OutB;
  logic          wb_valid;
  logic [AW-1:0] wb_dest;
  logic [DW-1:0] wb_data;
  logic          ex_valid;
  logic          ex_ready;
  logic [3:0]    ex_op;
  logic [AW-1:0] ex_dest;
  logic          ex_wr;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [DW-1:0] ex_imm;
  logic [DW-1:0] ex_pc;
  logic          ex_ill;

  modport master (
    output in_valid, in_instr, in_pc, OutA, OutB, wb_valid, wb_dest, wb_data, ex_ready,
    input  in_ready, ReadA, ReadB, ex_valid, ex_op, ex_dest, ex_wr, ex_a, ex_b,
           ex_imm, ex_pc, ex_ill
  );

  modport slave (
    input  in_valid, in_instr, in_pc, OutA, OutB, wb_valid, wb_dest, wb_data, ex_ready,
    output in_ready, ReadA, ReadB, ex_valid, ex_op, ex_dest, ex_wr, ex_a, ex_b,
           ex_imm, ex_pc, ex_ill
  );
endinterface

// File: rtl/regread_issue.sv
// Decode/issue stage: drives regfile read addresses, tracks pending writes in a
// scoreboard, stalls on RAW/WAW hazards and bypasses same-cycle writeback data.
module regread_issue #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic           clk,
  input  logic           rst,
  regread_issue_if.slave bus
);
  localparam int NREG = 1 << AW;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LHI  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  logic [3:0]    op;
  logic [AW-1:0] rd, rs1, rs2, src_b;
  logic          use_a, use_b, dec_wr, dec_ill;
  logic [DW-1:0] dec_imm;

  logic [NREG-1:0] busy_q, busy_d;
  logic            ex_valid_q, ex_valid_d;
  logic [3:0]      ex_op_q, ex_op_d;
  logic [AW-1:0]   ex_dest_q, ex_dest_d;
  logic            ex_wr_q, ex_wr_d;
  logic [DW-1:0]   ex_a_q, ex_a_d;
  logic [DW-1:0]   ex_b_q, ex_b_d;
  logic [DW-1:0]   ex_imm_q, ex_imm_d;
  logic [DW-1:0]   ex_pc_q, ex_pc_d;
  logic            ex_ill_q, ex_ill_d;

  logic haz_a, haz_b, haz_w, hazard, slot_free, issue;

  assign op    = bus.in_instr[15:12];
  assign rd    = bus.in_instr[11:9];
  assign rs1   = bus.in_instr[8:6];
  assign rs2   = bus.in_instr[5:3];
  assign src_b = (op == OP_SW || op == OP_BEQ) ? rd : rs2;

  always_comb begin
    use_a   = 1'b0;
    use_b   = 1'b0;
    dec_wr  = 1'b0;
    dec_ill = 1'b0;
    dec_imm = '0;
    case (op)
      OP_ADD, OP_NAND: begin
        use_a  = 1'b1;
        use_b  = 1'b1;
        dec_wr = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        use_a   = 1'b1;
        dec_wr  = 1'b1;
        dec_imm = {{(DW-6){bus.in_instr[5]}}, bus.in_instr[5:0]};
      end
      OP_LHI: begin
        dec_wr  = 1'b1;
        dec_imm = {bus.in_instr[8:0], 7'b0};
      end
      OP_SW, OP_BEQ: begin
        use_a   = 1'b1;
        use_b   = 1'b1;
        dec_imm = {{(DW-6){bus.in_instr[5]}}, bus.in_instr[5:0]};
      end
      OP_NOP: ;
      default: dec_ill = 1'b1;
    endcase
  end

  // A writeback landing this cycle already resolves the hazard on its register.
  assign haz_a  = use_a  && busy_q[rs1] && !(bus.wb_valid && bus.wb_dest == rs1);
  assign haz_b  = use_b  && busy_q[src_b] && !(bus.wb_valid && bus.wb_dest == src_b);
  assign haz_w  = dec_wr && busy_q[rd]  && !(bus.wb_valid && bus.wb_dest == rd);
  assign hazard = haz_a || haz_b || haz_w;

  assign slot_free    = !ex_valid_q || bus.ex_ready;
  assign issue        = bus.in_valid && !hazard && slot_free;
  assign bus.in_ready = !hazard && slot_free;
  assign bus.ReadA    = rs1;
  assign bus.ReadB    = src_b;

  // Per-register scoreboard bit; setting on issue overrides a coincident clear.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      always_comb begin
        busy_d[gi] = busy_q[gi];
        if (bus.wb_valid && bus.wb_dest == AW'(gi))
          busy_d[gi] = 1'b0;
        if (issue && dec_wr && rd == AW'(gi))
          busy_d[gi] = 1'b1;
      end
    end
  endgenerate

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_dest_d  = ex_dest_q;
    ex_wr_d    = ex_wr_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_imm_d   = ex_imm_q;
    ex_pc_d    = ex_pc_q;
    ex_ill_d   = ex_ill_q;
    if (issue) begin
      ex_valid_d = 1'b1;
      ex_op_d    = op;
      ex_dest_d  = rd;
      ex_wr_d    = dec_wr;
      ex_imm_d   = dec_imm;
      ex_pc_d    = bus.in_pc;
      ex_ill_d   = dec_ill;
      ex_a_d     = !use_a ? '0 : (bus.wb_valid && bus.wb_dest == rs1)   ? bus.wb_data : bus.OutA;
      ex_b_d     = !use_b ? '0 : (bus.wb_valid && bus.wb_dest == src_b) ? bus.wb_data : bus.OutB;
    end else if (bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_dest_q  <= '0;
      ex_wr_q    <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      ex_pc_q    <= '0;
      ex_ill_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_dest_q  <= ex_dest_d;
      ex_wr_q    <= ex_wr_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
      ex_pc_q    <= ex_pc_d;
      ex_ill_q   <= ex_ill_d;
    end
  end

  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_op    = ex_op_q;
  assign bus.ex_dest  = ex_dest_q;
  assign bus.ex_wr    = ex_wr_q;
  assign bus.ex_a     = ex_a_q;
  assign bus.ex_b     = ex_b_q;
  assign bus.ex_imm   = ex_imm_q;
  assign bus.ex_pc    = ex_pc_q;
  assign bus.ex_ill   = ex_ill_q;
endmodule

// File: tb/tb_regread_issue.sv
// Directed bench for regread_issue: hand-computed vectors checked with immediate assertions.
module tb_regread_issue;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  regread_issue_if #(.DW(16), .AW(3)) bus ();

  regread_issue #(.DW(16), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h0298;
    bus.in_pc    = 16'h0010;
    bus.OutA     = 16'h0000;
    bus.OutB     = 16'h0000;
    bus.wb_valid = 1'b0;
    bus.wb_dest  = 3'd0;
    bus.wb_data  = 16'h0000;
    bus.ex_ready = 1'b0;

    // reset with in_valid high
    tick();
    tick();
    chk("rst_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("rst_ex_a", {16'b0, bus.ex_a}, 32'h0);
    chk("rst_ex_b", {16'b0, bus.ex_b}, 32'h0);
    chk("rst_ex_imm", {16'b0, bus.ex_imm}, 32'h0);
    chk("rst_busy", {24'b0, dut.busy_q}, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", {31'b0, bus.in_ready}, 32'h1);
    chk("add_reada", {29'b0, bus.ReadA}, 32'h2);
    chk("add_readb", {29'b0, bus.ReadB}, 32'h3);

    // ADD R1,R2,R3
    bus.OutA = 16'h0005;
    bus.OutB = 16'h0007;
    tick();
    chk("add_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("add_op", {28'b0, bus.ex_op}, 32'h0);
    chk("add_dest", {29'b0, bus.ex_dest}, 32'h1);
    chk("add_a", {16'b0, bus.ex_a}, 32'h5);
    chk("add_b", {16'b0, bus.ex_b}, 32'h7);
    chk("add_wr", {31'b0, bus.ex_wr}, 32'h1);
    chk("add_pc", {16'b0, bus.ex_pc}, 32'h10);
    chk("add_busy", {24'b0, dut.busy_q}, 32'h02);

    // ADDI R4,R1,-1 stalls on R1 until writeback
    bus.in_instr = 16'h187F;
    bus.in_pc    = 16'h0011;
    bus.ex_ready = 1'b1;
    bus.OutA     = 16'hDEAD;
    #1;
    chk("raw_stall0", {31'b0, bus.in_ready}, 32'h0);
    tick();
    chk("raw_drain", {31'b0, bus.ex_valid}, 32'h0);
    chk("raw_stall1", {31'b0, bus.in_ready}, 32'h0);
    tick();
    chk("raw_stall2", {31'b0, bus.in_ready}, 32'h0);
    bus.wb_valid = 1'b1;
    bus.wb_dest  = 3'd1;
    bus.wb_data  = 16'h1234;
    #1;
    chk("raw_wb_rdy", {31'b0, bus.in_ready}, 32'h1);
    tick();
    chk("byp_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("byp_a", {16'b0, bus.ex_a}, 32'h1234);
    chk("byp_b", {16'b0, bus.ex_b}, 32'h0);
    chk("byp_imm", {16'b0, bus.ex_imm}, 32'hFFFF);
    chk("byp_dest", {29'b0, bus.ex_dest}, 32'h4);
    chk("byp_busy", {24'b0, dut.busy_q}, 32'h10);

    // NAND R5,R6,R0 held back by ex_ready low for 3 cycles
    bus.wb_valid = 1'b0;
    bus.ex_ready = 1'b0;
    bus.in_instr = 16'h2B80;
    bus.in_pc    = 16'h0012;
    bus.OutA     = 16'h1111;
    bus.OutB     = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_rdy", {31'b0, bus.in_ready}, 32'h0);
      tick();
      chk("hold_valid", {31'b0, bus.ex_valid}, 32'h1);
      chk("hold_a", {16'b0, bus.ex_a}, 32'h1234);
      chk("hold_dest", {29'b0, bus.ex_dest}, 32'h4);
      chk("hold_pc", {16'b0, bus.ex_pc}, 32'h11);
    end
    bus.ex_ready = 1'b1;
    #1;
    chk("rel_rdy", {31'b0, bus.in_ready}, 32'h1);
    tick();
    chk("nand_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("nand_op", {28'b0, bus.ex_op}, 32'h2);
    chk("nand_dest", {29'b0, bus.ex_dest}, 32'h5);
    chk("nand_a", {16'b0, bus.ex_a}, 32'h1111);
    chk("nand_b", {16'b0, bus.ex_b}, 32'h2222);
    chk("nand_busy", {24'b0, dut.busy_q}, 32'h30);

    // LHI R7,0x1FF
    bus.in_instr = 16'h3FFF;
    bus.in_pc    = 16'h0013;
    tick();
    chk("lhi_imm", {16'b0, bus.ex_imm}, 32'hFF80);
    chk("lhi_dest", {29'b0, bus.ex_dest}, 32'h7);
    chk("lhi_a", {16'b0, bus.ex_a}, 32'h0);
    chk("lhi_busy", {24'b0, dut.busy_q}, 32'hB0);

    // ADDI R7,R0,2 issues alongside writeback of R7: set wins
    bus.in_instr = 16'h1E02;
    bus.in_pc    = 16'h0014;
    bus.OutA     = 16'h0003;
    bus.wb_valid = 1'b1;
    bus.wb_dest  = 3'd7;
    bus.wb_data  = 16'h7777;
    #1;
    chk("waw_wb_rdy", {31'b0, bus.in_ready}, 32'h1);
    tick();
    chk("r7_busy", {24'b0, dut.busy_q}, 32'hB0);
    chk("r7_a", {16'b0, bus.ex_a}, 32'h3);
    chk("r7_imm", {16'b0, bus.ex_imm}, 32'h2);

    // ADD R5,R0,R0 is a WAW hazard on busy R5
    bus.wb_valid = 1'b0;
    bus.in_instr = 16'h0A00;
    #1;
    chk("waw_stall", {31'b0, bus.in_ready}, 32'h0);

    // illegal opcode 0x9
    bus.in_instr = 16'h9000;
    bus.in_pc    = 16'h0015;
    #1;
    chk("ill_rdy", {31'b0, bus.in_ready}, 32'h1);
    tick();
    chk("ill_flag", {31'b0, bus.ex_ill}, 32'h1);
    chk("ill_wr", {31'b0, bus.ex_wr}, 32'h0);
    chk("ill_op", {28'b0, bus.ex_op}, 32'h9);
    chk("ill_busy", {24'b0, dut.busy_q}, 32'hB0);

    // SW R2,0(R3)
    bus.in_instr = 16'h54C0;
    bus.in_pc    = 16'h0016;
    bus.OutA     = 16'hAAAA;
    bus.OutB     = 16'h5555;
    #1;
    chk("sw_reada", {29'b0, bus.ReadA}, 32'h3);
    chk("sw_readb", {29'b0, bus.ReadB}, 32'h2);
    tick();
    chk("sw_wr", {31'b0, bus.ex_wr}, 32'h0);
    chk("sw_ill", {31'b0, bus.ex_ill}, 32'h0);
    chk("sw_a", {16'b0, bus.ex_a}, 32'hAAAA);
    chk("sw_b", {16'b0, bus.ex_b}, 32'h5555);
    chk("sw_busy", {24'b0, dut.busy_q}, 32'hB0);

    // reset while holding a stalled instruction
    bus.ex_ready = 1'b0;
    bus.in_instr = 16'hF000;
    tick();
    chk("stall_valid", {31'b0, bus.ex_valid}, 32'h1);
    rst = 1'b1;
    tick();
    chk("mrst_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("mrst_busy", {24'b0, dut.busy_q}, 32'h0);
    chk("mrst_a", {16'b0, bus.ex_a}, 32'h0);
    chk("mrst_pc", {16'b0, bus.ex_pc}, 32'h0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
